request_capture: RTL and testbench

REQUEST_CAPTURE -- requirements
Module: request_capture

---
 rtl/request_capture_pkg.sv | 21 ++
 rtl/request_capture_debounce_bit.sv | 55 +++++
 rtl/request_capture.sv | 103 ++++++++++
 tb/tb_request_capture.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/request_capture_pkg.sv
// -----------------------------------------------------------------------------
// request_capture_pkg
// Shared constants for the request capture block.
//   WIDTH_DEF     : default number of request lines
//   DB_CYCLES_DEF : default debounce length (stable synchronized cycles)
//   IDX_W         : ack index width for the default WIDTH
//   CNT_W         : debounce counter width (covers DB_CYCLES up to 15)
//   idx_width()   : ack index width for any WIDTH (never zero)
// -----------------------------------------------------------------------------
package request_capture_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int DB_CYCLES_DEF = 4;
    localparam int IDX_W         = $clog2(WIDTH_DEF);
    localparam int CNT_W         = 4;

    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/request_capture_debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// One request line: 2-flop synchronizer followed by a debounce counter.
// The debounced level flips only after the synchronized input has
// disagreed with it for DB_CYCLES consecutive cycles; any agreement in
// between restarts the count.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   i_raw   : raw asynchronous pad input
//   o_level : debounced level (registered)
// -----------------------------------------------------------------------------
module debounce_bit
    import request_capture_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level
);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync != r_level) begin
                // Flip on the edge where the count would reach DB_CYCLES.
                if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                    r_level <= r_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/request_capture.sv
// -----------------------------------------------------------------------------
// request_capture
// Synchronizes and debounces WIDTH raw request pins, turns each debounced
// rising level into a sticky pending bit, and lets a downstream encoder
// retire pending bits one at a time.
// Optional feature macro: REQ_CAPTURE_OVERFLOW_EN -- when defined, a new
// rising level on a line that is still pending (and not acked that cycle)
// sets a sticky per-line overflow flag, cleared only by reset. When
// undefined, overflow is constant 0.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req_in    : raw request pins (WIDTH)
//   ack_valid : encoder consumed one request this cycle
//   ack_idx   : index of the consumed request
//   level     : debounced level per line
//   pend      : sticky pending-request vector
//   any_pend  : OR of pend
//   overflow  : per-line sticky lost-request flag
// -----------------------------------------------------------------------------
module request_capture
    import request_capture_pkg::*;
#(
    parameter  int WIDTH     = WIDTH_DEF,
    parameter  int DB_CYCLES = DB_CYCLES_DEF,
    localparam int IW        = idx_width(WIDTH)
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req_in,
    input  logic             ack_valid,
    input  logic [IW-1:0]    ack_idx,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pend,
    output logic             any_pend,
    output logic [WIDTH-1:0] overflow
);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_ack;
    logic [WIDTH-1:0] r_level_q;
    logic [WIDTH-1:0] r_pend;

    for (genvar g = 0; g < WIDTH; g++) begin : g_line
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_raw   (req_in[g]),
            .o_level (w_level[g])
        );
    end

    // One-hot ack decode; indices at or beyond WIDTH match no line.
    always_comb begin
        w_ack = '0;
        if (ack_valid) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (ack_idx == IW'(i)) begin
                    w_ack[i] = 1'b1;
                end
            end
        end
    end

    assign w_rise = w_level & ~r_level_q;

    // Set has priority over a same-cycle ack on the same line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_q <= '0;
            r_pend    <= '0;
        end else begin
            r_level_q <= w_level;
            r_pend    <= (r_pend & ~w_ack) | w_rise;
        end
    end

`ifdef REQ_CAPTURE_OVERFLOW_EN
    logic [WIDTH-1:0] r_ovf;

    // A rise lands on a request the encoder has not yet taken: one is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= r_ovf | (w_rise & r_pend & ~w_ack);
        end
    end

    assign overflow = r_ovf;
`else
    assign overflow = '0;
`endif

    assign level    = w_level;
    assign pend     = r_pend;
    assign any_pend = |r_pend;

endmodule

// File: tb/tb_request_capture.sv
// -----------------------------------------------------------------------------
// tb_request_capture
// Scoreboard bench for request_capture (WIDTH=8, DB_CYCLES=4). Each scenario
// drives stimulus and queues the outputs expected at given edges after that
// point; run_sb advances the clock and retires queued expectations as their
// edge arrives. Edge 1 is the first rising edge after the stimulus change.
// -----------------------------------------------------------------------------
module tb_request_capture;

    localparam int K_LEVEL = 0;
    localparam int K_PEND  = 1;
    localparam int K_ANY   = 2;
    localparam int K_OVF   = 3;

    typedef struct {
        int         edge_no;
        string      tag;
        int         kind;
        logic [7:0] val;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_in;
    logic       ack_valid;
    logic [2:0] ack_idx;
    logic [7:0] level;
    logic [7:0] pend;
    logic       any_pend;
    logic [7:0] overflow;

    int   n_checks;
    int   n_errors;
    exp_t sb[$];

`ifdef REQ_CAPTURE_OVERFLOW_EN
    localparam logic [7:0] OVF_LINE1 = 8'h02;
`else
    localparam logic [7:0] OVF_LINE1 = 8'h00;
`endif

    request_capture #(
        .WIDTH     (8),
        .DB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .ack_valid (ack_valid),
        .ack_idx   (ack_idx),
        .level     (level),
        .pend      (pend),
        .any_pend  (any_pend),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic void expect_at(input int e, input string tag,
                                      input int kind, input logic [7:0] v);
        exp_t x;
        x.edge_no = e;
        x.tag     = tag;
        x.kind    = kind;
        x.val     = v;
        sb.push_back(x);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_entry(input exp_t x);
        case (x.kind)
            K_LEVEL: chk(x.tag, 32'(level), 32'(x.val));
            K_PEND:  chk(x.tag, 32'(pend), 32'(x.val));
            K_ANY:   chk(x.tag, 32'(any_pend), 32'(x.val));
            default: chk(x.tag, 32'(overflow), 32'(x.val));
        endcase
    endtask

    task automatic run_sb(input int n);
        for (int e = 1; e <= n; e++) begin
            tick();
            while (sb.size() > 0 && sb[0].edge_no == e) begin
                exp_t x;
                x = sb.pop_front();
                compare_entry(x);
            end
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_pend"}, 32'(pend), 32'd0);
        chk({tag, "_any"}, 32'(any_pend), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        req_in    = 8'h00;
        ack_valid = 1'b0;
        ack_idx   = 3'd0;

        // Reset state
        #2;
        check_all_zero("reset_async");
        tick();
        tick();
        check_all_zero("reset_held");

        // Single line held from release: level at edge 6, pend at edge 7
        req_in = 8'h04;
        rst_n  = 1'b1;
        expect_at(5, "lat_level5", K_LEVEL, 8'h00);
        expect_at(6, "lat_level6", K_LEVEL, 8'h04);
        expect_at(6, "lat_pend6",  K_PEND,  8'h00);
        expect_at(6, "lat_any6",   K_ANY,   8'h00);
        expect_at(7, "lat_pend7",  K_PEND,  8'h04);
        expect_at(7, "lat_any7",   K_ANY,   8'h01);
        run_sb(7);

        // Three-cycle glitch on line 0 is filtered out
        req_in = 8'h05;
        tick();
        tick();
        tick();
        req_in = 8'h04;
        expect_at(3,  "glitch_level3", K_LEVEL, 8'h04);
        expect_at(6,  "glitch_level6", K_LEVEL, 8'h04);
        expect_at(10, "glitch_level",  K_LEVEL, 8'h04);
        expect_at(10, "glitch_pend",   K_PEND,  8'h04);
        run_sb(10);

        // Ack line 2, then build pend=0A; falling line 2 must not set pend
        ack_valid = 1'b1;
        ack_idx   = 3'd2;
        expect_at(1, "ack2_pend", K_PEND, 8'h00);
        expect_at(1, "ack2_any",  K_ANY,  8'h00);
        run_sb(1);
        ack_valid = 1'b0;
        req_in    = 8'h0A;
        expect_at(6, "set0a_pend6", K_PEND,  8'h00);
        expect_at(6, "set0a_lvl6",  K_LEVEL, 8'h0A);
        expect_at(7, "set0a_pend7", K_PEND,  8'h0A);
        run_sb(7);

        ack_valid = 1'b1;
        ack_idx   = 3'd3;
        expect_at(1, "ack3_pend", K_PEND, 8'h02);
        run_sb(1);
        ack_idx = 3'd0;
        expect_at(1, "ack0_nop", K_PEND, 8'h02);
        run_sb(1);
        ack_valid = 1'b0;

        // Line 5: pend, release, re-assert with same-cycle ack (set wins)
        req_in = 8'h2A;
        expect_at(7, "l5_set_pend", K_PEND, 8'h22);
        run_sb(7);
        req_in = 8'h0A;
        expect_at(7, "l5_fall_pend", K_PEND,  8'h22);
        expect_at(7, "l5_fall_lvl",  K_LEVEL, 8'h0A);
        run_sb(7);
        req_in = 8'h2A;
        expect_at(6, "l5_rise_lvl", K_LEVEL, 8'h2A);
        run_sb(6);
        ack_valid = 1'b1;
        ack_idx   = 3'd5;
        expect_at(1, "setack_pend", K_PEND, 8'h22);
        expect_at(1, "setack_ovf",  K_OVF,  8'h00);
        run_sb(1);
        ack_valid = 1'b0;

        // Line 1 still pending: release and re-assert without ack
        req_in = 8'h28;
        expect_at(7, "l1_fall_lvl", K_LEVEL, 8'h28);
        expect_at(7, "l1_fall_ovf", K_OVF,   8'h00);
        run_sb(7);
        req_in = 8'h2A;
        expect_at(6, "ovf_edge6", K_OVF,  8'h00);
        expect_at(7, "ovf_edge7", K_OVF,  OVF_LINE1);
        expect_at(7, "ovf_pend",  K_PEND, 8'h22);
        expect_at(9, "ovf_hold",  K_OVF,  OVF_LINE1);
        run_sb(9);

        // Reset mid-debounce with all lines high
        req_in = 8'hFF;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        tick();
        tick();
        check_all_zero("rst_mid_held");
        rst_n = 1'b1;
        expect_at(6, "rel_pend6", K_PEND,  8'h00);
        expect_at(6, "rel_lvl6",  K_LEVEL, 8'hFF);
        expect_at(7, "rel_pend7", K_PEND,  8'hFF);
        expect_at(7, "rel_any7",  K_ANY,   8'h01);
        expect_at(7, "rel_ovf7",  K_OVF,   8'h00);
        run_sb(7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
